// File: rtl/spi_pkg.sv
// Shared types and defaults for the spi_master block.
package spi_pkg;

  typedef logic [7:0] byte_t;

  localparam int NSLAVES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/spi_master_if.sv
// Control-side request/response signals and the board-level SPI bus of spi_master.
interface spi_master_if import spi_pkg::*; #(
  parameter int NSLAVES = NSLAVES_DEF
);
  logic [NSLAVES-1:0] ss;
  logic               strobe;
  byte_t              toXmit;
  byte_t              Rcvd;
  logic               Ready;
  logic               busy;
  logic               SCLK;
  logic               MOSI;
  logic               MISO;
  logic [NSLAVES-1:0] SS_n;

  modport master (
    input  ss, strobe, toXmit, MISO,
    output Rcvd, Ready, busy, SCLK, MOSI, SS_n
  );

  modport slave (
    output ss, strobe, toXmit, MISO,
    input  Rcvd, Ready, busy, SCLK, MOSI, SS_n
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK half-period timer: down-counter of CLK_DIV clocks producing a tick at the
// end of each half-period and the running half-period index while run_i is high.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic       Clk_i,
  input  logic       Rst_i,
  input  logic       run_i,
  output logic       tick_o,
  output logic [4:0] half_o
);
  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    half_q, half_d;

  always_comb begin
    tick_o = run_i && (cnt_q == '0);
    cnt_d  = cnt_q;
    half_d = half_q;
    if (!run_i) begin
      cnt_d  = LOAD;
      half_d = '0;
    end else if (tick_o) begin
      cnt_d  = LOAD;
      half_d = half_q + 5'd1;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      cnt_q  <= LOAD;
      half_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
    end
  end

  assign half_o = half_q;
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, 8-bit MSB-first full duplex, NSLAVES shared-bus slaves.
// Define SPI_MASTER_ASSERT_EN to compile in simulation assertions.
//
// state | meaning
// IDLE  | waiting for a strobe rising edge with a non-zero ss
// SHIFT | 16 SCLK half-periods; sample MISO on rise, advance MOSI on fall
// HOLD  | one half-period with SCLK low and the select still asserted
// DONE  | select released; Rcvd/Ready updated on the way back to IDLE
module spi_master import spi_pkg::*; #(
  parameter int NSLAVES = NSLAVES_DEF,
  parameter int CLK_DIV = 2
) (
  input logic          Clk_i,
  input logic          Rst_i,
  spi_master_if.master bus
);
  state_e             state_q, state_d;
  logic               strobe_q, strobe_d;
  byte_t              tx_q, tx_d;
  byte_t              rx_q, rx_d;
  byte_t              rcvd_q, rcvd_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic [NSLAVES-1:0] ss_n_q, ss_n_d;

  logic               start;
  logic [NSLAVES-1:0] lowest_sel;
  logic               run;
  logic               tick;
  logic [4:0]         half;

  assign start      = bus.strobe & ~strobe_q;
  assign lowest_sel = bus.ss & (~bus.ss + NSLAVES'(1));
  assign run        = (state_q == SHIFT) || (state_q == HOLD);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .Clk_i  (Clk_i),
    .Rst_i  (Rst_i),
    .run_i  (run),
    .tick_o (tick),
    .half_o (half)
  );

  always_comb begin
    state_d  = state_q;
    strobe_d = bus.strobe;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rcvd_d   = rcvd_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ss_n_d   = ss_n_q;
    case (state_q)
      IDLE: begin
        if (start && (bus.ss != '0)) begin
          tx_d    = bus.toXmit;
          ss_n_d  = ~lowest_sel;
          busy_d  = 1'b1;
          mosi_d  = bus.toXmit[7];
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!half[0]) begin
            rx_d   = {rx_q[6:0], bus.MISO};
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (half != 5'd15) begin
              // rotate so the next bit to send is always in bit 7
              tx_d   = {tx_q[6:0], tx_q[7]};
              mosi_d = tx_q[6];
            end else begin
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          ss_n_d  = '1;
          state_d = DONE;
        end
      end
      DONE: begin
        rcvd_d  = rx_q;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q  <= IDLE;
      strobe_q <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      rcvd_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ss_n_q   <= '1;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rcvd_q   <= rcvd_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ss_n_q   <= ss_n_d;
    end
  end

  assign bus.Rcvd  = rcvd_q;
  assign bus.Ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.SCLK  = sclk_q;
  assign bus.MOSI  = mosi_q;
  assign bus.SS_n  = ss_n_q;

`ifdef SPI_MASTER_ASSERT_EN
  a_ss_onehot: assert property (@(posedge Clk_i) disable iff (Rst_i)
    start |-> $onehot(bus.ss))
    else $error("spi_master: ss not one-hot at start edge");
  a_no_start_busy: assert property (@(posedge Clk_i) disable iff (Rst_i)
    start |-> !busy_q)
    else $error("spi_master: start edge while busy");
  a_one_select: assert property (@(posedge Clk_i) disable iff (Rst_i)
    $countones(~ss_n_q) <= 1)
    else $error("spi_master: more than one SS_n low");
  a_ready_pulse: assert property (@(posedge Clk_i) disable iff (Rst_i)
    ready_q |=> !ready_q)
    else $error("spi_master: Ready high two cycles");
`endif
endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master: two behavioural mode-0 slaves plus a
// transfer-level reference model of selection, data, and timing.
module tb_spi_master;
  import spi_pkg::*;

  localparam int CD      = 2;
  localparam int LATENCY = 17 * CD + 1;

  logic clk;
  logic rst;

  spi_master_if #(.NSLAVES(2)) bus ();

  spi_master #(.NSLAVES(2), .CLK_DIV(CD)) dut (
    .Clk_i (clk),
    .Rst_i (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave side: each slave shifts out its byte MSB first, advancing on SCLK falls.
  byte_t      slv_data [0:1];
  logic [3:0] bit_idx;
  logic       ss_idle;
  logic       miso_w;

  assign ss_idle  = &bus.SS_n;
  assign bus.MISO = miso_w;

  always @(negedge bus.SCLK or posedge ss_idle) begin
    if (ss_idle) bit_idx <= 4'd0;
    else         bit_idx <= bit_idx + 4'd1;
  end

  always_comb begin
    miso_w = 1'b0;
    for (int i = 0; i < 2; i++)
      if (bus.SS_n[i] == 1'b0 && bit_idx < 4'd8)
        miso_w = slv_data[i][3'd7 - bit_idx[2:0]];
  end

  // Observation of the bus, sampled away from the active edge.
  logic mosi_bits[$];
  int   cyc = 0;
  int   ss_low_cyc, ready_cyc, ready_cnt, busy_cnt, multi_low;
  logic [1:0] ss_seen;

  always @(posedge bus.SCLK) mosi_bits.push_back(bus.MOSI);

  always @(negedge clk) begin
    cyc++;
    if (bus.SS_n != 2'b11) begin
      if (ss_low_cyc < 0) ss_low_cyc = cyc;
      ss_seen = ss_seen & bus.SS_n;
    end
    if ($countones(~bus.SS_n) > 1) multi_low++;
    if (bus.Ready === 1'b1) begin
      ready_cnt++;
      ready_cyc = cyc;
    end
    if (bus.busy === 1'b1) busy_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ss_low_cyc = -1;
    ready_cyc  = -1;
    ready_cnt  = 0;
    busy_cnt   = 0;
    multi_low  = 0;
    ss_seen    = 2'b11;
    mosi_bits.delete();
  endtask

  task automatic start_xfer(input byte_t tx, input logic [1:0] ss);
    bus.toXmit = tx;
    bus.ss     = ss;
    bus.strobe = 1'b1;
    tick();
    bus.strobe = 1'b0;
  endtask

  byte_t exp_rcvd;

  task automatic run_xfer(input string tag, input byte_t tx, input logic [1:0] ss,
                          input int poke_at, input int post_wait);
    int    sel;
    byte_t got_mosi;
    clear_mon();
    start_xfer(tx, ss);
    sel = -1;
    for (int i = 0; i < 2; i++) if (ss[i] && sel < 0) sel = i;
    for (int k = 0; k < 80 && ready_cnt == 0; k++) begin
      if (poke_at > 0 && k == poke_at) start_xfer(8'h00, ss);
      tick();
    end
    repeat (6 + post_wait) tick();
    if (sel < 0) begin
      chk({tag, "_ready_cnt"}, ready_cnt, 0);
      chk({tag, "_ss_seen"},   ss_seen,   2'b11);
      chk({tag, "_busy_cnt"},  busy_cnt,  0);
      chk({tag, "_rcvd_kept"}, bus.Rcvd,  exp_rcvd);
    end else begin
      exp_rcvd = slv_data[sel];
      got_mosi = '0;
      for (int i = 0; i < 8 && i < mosi_bits.size(); i++)
        got_mosi = {got_mosi[6:0], mosi_bits[i]};
      chk({tag, "_ss_seen"},   ss_seen,              2'b11 & ~(2'b01 << sel));
      chk({tag, "_ready_cnt"}, ready_cnt,            1);
      chk({tag, "_rcvd"},      bus.Rcvd,             exp_rcvd);
      chk({tag, "_latency"},   ready_cyc - ss_low_cyc, LATENCY);
      chk({tag, "_mosi"},      got_mosi,             tx);
      chk({tag, "_rises"},     mosi_bits.size(),     8);
      chk({tag, "_busy_cnt"},  busy_cnt,             LATENCY);
      chk({tag, "_multi_low"}, multi_low,            0);
    end
    chk({tag, "_idle_ssn"},  bus.SS_n, 2'b11);
    chk({tag, "_idle_sclk"}, bus.SCLK, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bus.ss     = 2'b00;
    bus.strobe = 1'b0;
    bus.toXmit = 8'h00;
    slv_data[0] = 8'h00;
    slv_data[1] = 8'h00;
    exp_rcvd   = 8'h00;
    clear_mon();
    repeat (2) tick();
    chk("rst_ssn",   bus.SS_n,  2'b11);
    chk("rst_sclk",  bus.SCLK,  1'b0);
    chk("rst_mosi",  bus.MOSI,  1'b0);
    chk("rst_ready", bus.Ready, 1'b0);
    chk("rst_busy",  bus.busy,  1'b0);
    chk("rst_rcvd",  bus.Rcvd,  8'h00);
    rst = 1'b0;
    repeat (3) tick();

    slv_data[0] = 8'h3C;
    run_xfer("s0", 8'hA5, 2'b01, 0, 0);
    slv_data[1] = 8'hFF;
    run_xfer("s1", 8'h81, 2'b10, 0, 0);
    slv_data[0] = 8'hC3;
    run_xfer("busy", 8'hA5, 2'b01, 9, 50);
    run_xfer("ss00", 8'h5A, 2'b00, 0, 0);
    slv_data[0] = 8'h5A;
    run_xfer("ss11", 8'h0F, 2'b11, 0, 0);

    // abort in half-period 7 (SCLK high), after a non-zero Rcvd is present
    clear_mon();
    slv_data[1] = 8'h66;
    start_xfer(8'h96, 2'b10);
    for (int k = 0; k < 60 && !(ss_low_cyc >= 0 && cyc == ss_low_cyc + 7 * CD); k++) tick();
    chk("abort_h7_sclk", bus.SCLK, 1'b1);
    chk("abort_h7_ssn",  bus.SS_n, 2'b01);
    rst = 1'b1;
    tick();
    chk("abort_ssn",  bus.SS_n, 2'b11);
    chk("abort_sclk", bus.SCLK, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_rcvd", bus.Rcvd, 8'h00);
    rst = 1'b0;
    exp_rcvd = 8'h00;
    repeat (60) tick();
    chk("abort_no_ready", ready_cnt, 0);

    for (int n = 0; n < 24; n++) begin
      slv_data[0] = byte_t'($urandom);
      slv_data[1] = byte_t'($urandom);
      repeat ($urandom_range(0, 5)) tick();
      run_xfer($sformatf("rnd%0d", n), byte_t'($urandom), 2'($urandom_range(0, 3)), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
